// File: rtl/qspi_flash_responder_if.sv
// Bus bundle between a QSPI read master (plus its backing memory) and the
// flash responder. The responder takes the slave view; the environment
// driving sclk/cs_n/mosi and serving memory reads takes the master view.
interface qspi_flash_responder_if #(
    parameter int ADDR_WIDTH = 24
);
    logic                  sclk;
    logic                  cs_n;
    logic                  mosi;
    logic [3:0]            io_out;
    logic [3:0]            io_oe;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_rdata;
    logic                  busy;
    logic                  bad_opcode;

    modport slave (
        input  sclk, cs_n, mosi, mem_rdata,
        output io_out, io_oe, mem_rd_en, mem_addr, busy, bad_opcode
    );

    modport master (
        output sclk, cs_n, mosi, mem_rdata,
        input  io_out, io_oe, mem_rd_en, mem_addr, busy, bad_opcode
    );
endinterface

// File: rtl/qspi_flash_responder.sv
// QSPI flash responder: receives opcode and 24-bit address on mosi, then
// streams bytes from a fixed-latency memory port on one (0x03) or four
// (0x6B) data lines. All SPI inputs are oversampled in the clk domain.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | cs_n high, nothing in flight
// CMD    | shifting in the 8-bit opcode
// ADDR   | shifting in the 24-bit address
// DUMMY  | counting dummy sclk cycles (0x6B only)
// DATA   | streaming bytes out, prefetching the next byte
// IGNORE | unsupported opcode, wait for cs_n to rise
module qspi_flash_responder #(
    parameter int ADDR_WIDTH   = 24,
    parameter int DUMMY_CYCLES = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int MEM_LATENCY  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    qspi_flash_responder_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_IGNORE
    } state_t;

    localparam logic [7:0] OP_READ    = 8'h03;
    localparam logic [7:0] OP_QREAD   = 8'h6B;
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev;
    logic                   sclk_s, cs_high, mosi_s;
    logic                   sclk_rise, sclk_fall;

    logic [7:0]            bit_cnt;
    logic [6:0]            cmd_sh;
    logic [22:0]           addr_sh;
    logic                  quad;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [MEM_LATENCY-1:0] rd_pipe;
    logic [7:0]            pf;
    logic                  pf_valid;
    logic [7:0]            sh;
    logic                  sh_valid;
    logic [2:0]            pos;
    logic [3:0]            io_out_q, io_oe_q;

    logic [7:0]            cmd_word;
    logic [23:0]           addr_full;
    logic [ADDR_WIDTH-1:0] addr_rx, addr_nx;
    logic                  last_pos;
    logic                  bad_op, addr_done, load_first, load_next, rd_en;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_high   = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    // an sclk edge coinciding with cs_n high is dropped: cs_n wins
    assign sclk_rise = sclk_s & ~sclk_prev & ~cs_high;
    assign sclk_fall = ~sclk_s & sclk_prev & ~cs_high;

    assign cmd_word  = {cmd_sh, mosi_s};
    assign addr_full = {addr_sh, mosi_s};
    assign addr_rx   = addr_full[ADDR_WIDTH-1:0];
    assign addr_nx   = addr_done ? addr_rx
                                 : addr_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    assign last_pos  = quad ? (pos == 3'd1) : (pos == 3'd7);
    assign rd_en     = addr_done | load_first | load_next;

    assign bus.mem_rd_en  = rd_en;
    assign bus.mem_addr   = rd_en ? addr_nx : '0;
    assign bus.io_out     = io_out_q;
    assign bus.io_oe      = io_oe_q;
    assign bus.busy       = (state != S_IDLE);
    assign bus.bad_opcode = bad_op;

    // input synchronizers and sclk history for edge detection; cs_n
    // resets to the deselected level so reset never looks like a select
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            sclk_prev <= sclk_s;
        end
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state decode and single-cycle control strobes
    always_comb begin
        state_nx   = state;
        bad_op     = 1'b0;
        addr_done  = 1'b0;
        load_first = 1'b0;
        load_next  = 1'b0;
        if (cs_high) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: state_nx = S_CMD;
                S_CMD: begin
                    if (sclk_rise && bit_cnt == 8'd7) begin
                        if (cmd_word == OP_READ || cmd_word == OP_QREAD) begin
                            state_nx = S_ADDR;
                        end else begin
                            bad_op   = 1'b1;
                            state_nx = S_IGNORE;
                        end
                    end
                end
                S_ADDR: begin
                    if (sclk_rise && bit_cnt == 8'd23) begin
                        addr_done = 1'b1;
                        if (!quad || DUMMY_CYCLES == 0) begin
                            state_nx = S_DATA;
                        end else begin
                            state_nx = S_DUMMY;
                        end
                    end
                end
                S_DUMMY: begin
                    if (sclk_rise && bit_cnt == DUMMY_LAST) begin
                        state_nx = S_DATA;
                    end
                end
                S_DATA: begin
                    if (!sh_valid && pf_valid) begin
                        load_first = 1'b1;
                    end
                    if (sclk_fall && sh_valid && last_pos) begin
                        load_next = 1'b1;
                    end
                end
                default: state_nx = state;
            endcase
        end
    end

    // shift registers, address counter, read pipeline and output drive
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= '0;
            cmd_sh   <= '0;
            addr_sh  <= '0;
            quad     <= 1'b0;
            addr_cnt <= '0;
            rd_pipe  <= '0;
            pf       <= '0;
            pf_valid <= 1'b0;
            sh       <= '0;
            sh_valid <= 1'b0;
            pos      <= '0;
            io_out_q <= '0;
            io_oe_q  <= '0;
        end else if (cs_high) begin
            bit_cnt  <= '0;
            cmd_sh   <= '0;
            addr_sh  <= '0;
            quad     <= 1'b0;
            addr_cnt <= '0;
            rd_pipe  <= '0;
            pf_valid <= 1'b0;
            sh       <= '0;
            sh_valid <= 1'b0;
            pos      <= '0;
            io_out_q <= '0;
            io_oe_q  <= '0;
        end else begin
            rd_pipe[0] <= rd_en;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            if (rd_pipe[MEM_LATENCY-1]) begin
                pf       <= bus.mem_rdata;
                pf_valid <= 1'b1;
            end
            if (rd_en) begin
                addr_cnt <= addr_nx;
            end
            if (sclk_rise) begin
                case (state)
                    S_CMD: begin
                        cmd_sh  <= cmd_word[6:0];
                        bit_cnt <= (bit_cnt == 8'd7) ? 8'd0 : bit_cnt + 8'd1;
                        if (bit_cnt == 8'd7) begin
                            quad <= (cmd_word == OP_QREAD);
                        end
                    end
                    S_ADDR: begin
                        addr_sh <= addr_full[22:0];
                        bit_cnt <= (bit_cnt == 8'd23) ? 8'd0 : bit_cnt + 8'd1;
                    end
                    S_DUMMY: begin
                        bit_cnt <= (bit_cnt == DUMMY_LAST) ? 8'd0 : bit_cnt + 8'd1;
                    end
                    default: ;
                endcase
            end
            if (load_first) begin
                sh       <= pf;
                sh_valid <= 1'b1;
                pf_valid <= 1'b0;
                pos      <= '0;
            end
            if (sclk_fall && state == S_DATA && sh_valid) begin
                io_oe_q  <= quad ? 4'b1111 : 4'b0001;
                io_out_q <= quad ? sh[7:4] : {3'b000, sh[7]};
                if (load_next) begin
                    sh       <= pf;
                    pf_valid <= 1'b0;
                    pos      <= '0;
                end else begin
                    sh  <= quad ? {sh[3:0], 4'h0} : {sh[6:0], 1'b0};
                    pos <= pos + 3'd1;
                end
            end
        end
    end
endmodule

// File: doc/qspi_flash_responder.md
Name: qspi_flash_responder

Overview:
- Synthesizable QSPI flash responder: the target side of the design's QSPI read master.
- Decodes an 8-bit opcode and a 24-bit address shifted in on a single line, then streams bytes from an on-chip memory port back on one or four lines.
- Used as an in-FPGA flash stand-in for simulation and bring-up of the frame-streaming path, and as the reference target for master regression benches.

Parameters:
- ADDR_WIDTH, 24, byte address width; the address counter wraps modulo 2^ADDR_WIDTH. Values below 24 keep the low ADDR_WIDTH bits of the received 24-bit address.
- DUMMY_CYCLES, 8, sclk cycles between the last address bit and the first data nibble for opcode 0x6B.
- SYNC_STAGES, 2, synchronizer flops on sclk, cs_n and mosi (minimum 2).
- MEM_LATENCY, 1, clk cycles from mem_rd_en to a valid mem_rdata (fixed, BRAM-style).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock from the master (mode 0, idle low).
- cs_n  in  1  chip select, active low.
- mosi  in  1  serial command/address line from the master.
- io_out  out  4  data to the master; single mode drives bit 0 only.
- io_oe  out  4  per-line output enable.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_addr  out  ADDR_WIDTH  read address, valid with mem_rd_en.
- mem_rdata  in  8  read data, valid MEM_LATENCY cycles after mem_rd_en.
- busy  out  1  high from cs_n falling to cs_n rising.
- bad_opcode  out  1  one-cycle pulse when an unsupported opcode completes.

Behaviour:
- Reset values: all outputs 0; state IDLE; shift registers and address counter 0.
- Inputs sclk, cs_n and mosi are synchronized (SYNC_STAGES flops), then edge-detected in the clk domain.
- Rising sclk edge = sample mosi. Falling sclk edge = advance io_out.
- Required ratio: sclk high and low phases are each at least SYNC_STAGES+MEM_LATENCY+2 clk cycles.
- cs_n high (synchronized), from any state: go to IDLE in the next clk. io_oe=0, busy=0, in-flight memory read discarded, bit counters cleared.
- State IDLE: on cs_n low, go to CMD; busy=1.
- State CMD: shift 8 mosi bits MSB-first on rising edges. On the 8th bit:
  - 0x03 or 0x6B: go to ADDR.
  - any other value: pulse bad_opcode, go to IGNORE.
- State ADDR: shift 24 bits MSB-first. On the 24th rising edge:
  - load the address counter;
  - assert mem_rd_en with mem_addr = that address in the same clk;
  - go to DATA for 0x03, or to DUMMY for 0x6B (DUMMY_CYCLES=0 goes straight to DATA).
- State DUMMY: count DUMMY_CYCLES rising edges, then go to DATA. io_oe stays 0. mosi is ignored.
- State DATA, first byte: the fetched byte loads into the output shift register before the next falling edge. On that falling edge, drive the first bit or nibble and set io_oe:
  - 0x03: io_oe=4'b0001.
  - 0x6B: io_oe=4'b1111.
- State DATA, shifting:
  - 0x03: MSB-first, 8 falling edges per byte, on io_out[0]; io_out[3:1]=0.
  - 0x6B: high nibble then low nibble, 2 falling edges per byte, on io_out[3:0].
- State DATA, prefetch: when a byte is loaded into the shift register, increment the address counter (wrap 2^ADDR_WIDTH-1 to 0) and issue mem_rd_en for the next byte. The result is held in a prefetch register and loaded when the last bit or nibble of the current byte is shifted out. The stream continues without gaps until cs_n rises.
- State DATA, mosi is ignored.
- State IGNORE: io_oe=0; hold until cs_n rises.
- cs_n rising mid-byte or mid-address: the transaction aborts with no partial state kept; the next transaction starts clean.
- Simultaneous sclk edge and cs_n rise in the same clk: cs_n wins; the edge is ignored.
- sclk edges while cs_n is high are ignored.
- Reset asserted mid-transfer: io_oe=0 immediately (asynchronous), with no further memory reads.

Test Plan:
- Memory holds byte at address i = i[7:0]. cs_n low; send 0x03, address 0x000010; 16 sclk -> io_out[0] serial bytes 0x10, 0x11 MSB-first; io_oe=0001 from the first data falling edge; mem_addr 0x10, 0x11, 0x12 in order.
- Send 0x6B, address 0x0000FE, 8 dummy cycles, 6 data cycles -> nibbles F,E,F,F,0,0 on io_out[3:0]; io_oe=1111 only after the dummy cycles; address wraps 0x0000FF -> 0x000100 (and 0xFFFFFF -> 0x000000 when tested at the top of the space).
- Send opcode 0x9F -> bad_opcode pulses exactly once; io_oe stays 0; no mem_rd_en; next transaction 0x03 @ 0x000000 returns 0x00.
- Raise cs_n after 12 address bits, then start a new 0x03 @ 0x000020 -> returns 0x20, with no corruption from the aborted frame.
- Assert reset during a 0x6B data phase -> io_oe, busy and mem_rd_en go to 0 without waiting for a clk edge; after release, the next read works normally.
- Connect the design's QSPI read master (clock divider 8, qio_mode=1, tx 0x6B plus 24-bit address 0x000040, 8 dummy cycles, rx 32 bits) -> master rx_data=0x40414243.
